// File: rtl/dff_pipe_pkg.sv
// Shared types and sizing helpers for the dff_pipe delay line.
// DFF_PIPE_PARITY_EN adds a per-stage parity bit to the stage tag.
package dff_pipe_pkg;

  localparam int DFF_PIPE_WIDTH = 8;
  localparam int DFF_PIPE_DEPTH = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Sideband that travels with each data word.
  typedef struct packed {
    logic vld;
`ifdef DFF_PIPE_PARITY_EN
    logic par;
`endif
  } stageTag_t;

endpackage

// File: rtl/dff_pipe_stage.sv
// One enabled, flushable register of a data word plus its tag.
// Parity reset value follows RST_VAL under DFF_PIPE_PARITY_EN.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int              WIDTH   = DFF_PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             c,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  stageTag_t        dTag,
  output logic [WIDTH-1:0] q,
  output stageTag_t        qTag
);

`ifdef DFF_PIPE_PARITY_EN
  localparam stageTag_t RST_TAG = '{vld: 1'b0, par: ^RST_VAL};
`else
  localparam stageTag_t RST_TAG = '{vld: 1'b0};
`endif

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      q    <= RST_VAL;
      qTag <= RST_TAG;
    end else if (flush) begin
      q    <= RST_VAL;
      qTag <= RST_TAG;
    end else if (en) begin
      q    <= d;
      qTag <= dTag;
    end
  end

endmodule

// File: rtl/dff_pipe_always_ff.sv
// WIDTH x DEPTH enabled delay line with valid tracking and occupancy count.
// DFF_PIPE_PARITY_EN enables per-stage parity and the sticky perr flag.
module dff_pipe_always_ff
  import dff_pipe_pkg::*;
#(
  parameter int              WIDTH   = DFF_PIPE_WIDTH,
  parameter int              DEPTH   = DFF_PIPE_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                      c,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      flush,
  input  logic [WIDTH-1:0]          d,
  input  logic                      vin,
  output logic [WIDTH-1:0]          q,
  output logic                      vout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      perr
);

  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] stageData [DEPTH+1];
  stageTag_t        stageTag  [DEPTH+1];

  assign stageData[0]    = d;
  assign stageTag[0].vld = vin;
`ifdef DFF_PIPE_PARITY_EN
  assign stageTag[0].par = ^d;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    dff_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) uStage (
      .c     (c),
      .rst   (rst),
      .en    (en),
      .flush (flush),
      .d     (stageData[i]),
      .dTag  (stageTag[i]),
      .q     (stageData[i+1]),
      .qTag  (stageTag[i+1])
    );
  end

  assign q    = stageData[DEPTH];
  assign vout = stageTag[DEPTH].vld;

  // A word entering and one leaving on the same edge cancel out.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(vin) - CW'(vout);
    end
  end

`ifdef DFF_PIPE_PARITY_EN
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
    end else if (flush) begin
      perr <= 1'b0;
    end else if (vout && (stageTag[DEPTH].par != ^q)) begin
      perr <= 1'b1;
    end
  end
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_dff_pipe_always_ff.sv
// Directed bench for dff_pipe_always_ff (WIDTH=8, DEPTH=4, RST_VAL=8'h5A).
// Parity scenario is built only when DFF_PIPE_PARITY_EN is defined.
module tb_dff_pipe_always_ff;
  import dff_pipe_pkg::*;

  localparam int              W  = 8;
  localparam int              D  = 4;
  localparam logic [W-1:0]    RV = 8'h5A;
  localparam int              CW = cnt_w(D);

  logic          c = 1'b0;
  logic          rst, en, flush, vin;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          vout;
  logic [CW-1:0] count;
  logic          perr;

  int nCmp  = 0;
  int nFail = 0;

  dff_pipe_always_ff #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (RV)
  ) dut (
    .c     (c),
    .rst   (rst),
    .en    (en),
    .flush (flush),
    .d     (d),
    .vin   (vin),
    .q     (q),
    .vout  (vout),
    .count (count),
    .perr  (perr)
  );

  always #5 c = ~c;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic step();
    @(posedge c);
    #1;
  endtask

  task automatic drive(input logic e, input logic v, input logic [W-1:0] x);
    en  = e;
    vin = v;
    d   = x;
  endtask

  logic [3:0]    bubVin   = 4'b0101;
  logic [CW-1:0] bubCnt [7] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
  logic          bubVout[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef DFF_PIPE_PARITY_EN
  logic [W-1:0]  held;
`endif

  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 1'b0, '0);
    #3;
    chk("rst_q", 32'(q), 32'(RV));
    chk("rst_vout", 32'(vout), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_perr", 32'(perr), 0);
    #4 rst = 1'b0;
    @(posedge c); #1;

    // Latency and fill
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, W'(8'h11 * (i + 1)));
      step();
      chk("lat_count", 32'(count), (i < 4) ? i + 1 : 4);
      if (i == 3) begin
        chk("lat_q4", 32'(q), 32'h11);
        chk("lat_vout4", 32'(vout), 1);
      end
      if (i == 4) chk("lat_q5", 32'(q), 32'h22);
    end

    // Asynchronous reset between edges
    #3 rst = 1'b1;
    #1;
    chk("arst_q", 32'(q), 32'(RV));
    chk("arst_vout", 32'(vout), 0);
    chk("arst_count", 32'(count), 0);
    #1 rst = 1'b0;

    // Stall
    drive(1'b1, 1'b1, 8'hA1); step();
    drive(1'b1, 1'b1, 8'hA2); step();
    chk("stall_fill", 32'(count), 2);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 8'hFF); step();
      chk("stall_count", 32'(count), 2);
      chk("stall_q", 32'(q), 32'(RV));
      chk("stall_vout", 32'(vout), 0);
    end
    drive(1'b1, 1'b0, 8'h00); step();
    chk("resume_q1", 32'(q), 32'(RV));
    step();
    chk("resume_q2", 32'(q), 32'hA1);
    chk("resume_vout", 32'(vout), 1);
    chk("resume_count", 32'(count), 2);

    flush = 1'b1; step(); flush = 1'b0;
    chk("clr_count", 32'(count), 0);

    // Bubbles: invalid words still carry their data
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, bubVin[i], W'(8'hB1 + i));
      else       drive(1'b1, 1'b0, 8'h00);
      step();
      chk("bub_count", 32'(count), 32'(bubCnt[i]));
      chk("bub_vout", 32'(vout), 32'(bubVout[i]));
      if (i >= 3) chk("bub_q", 32'(q), 32'(8'hB1 + i - 3));
    end

    // Flush wins over en; the word offered that cycle is dropped
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, W'(8'hC1 + i)); step();
    end
    chk("fl_full", 32'(count), 4);
    flush = 1'b1;
    drive(1'b1, 1'b1, 8'hEE); step();
    flush = 1'b0;
    chk("fl_count", 32'(count), 0);
    chk("fl_vout", 32'(vout), 0);
    chk("fl_q", 32'(q), 32'(RV));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h00); step();
      chk("fl_noEE", 32'(q == 8'hEE), 0);
    end
    chk("fl_tail_q", 32'(q), 0);
    chk("fl_tail_v", 32'(vout), 0);

`ifdef DFF_PIPE_PARITY_EN
    // Corrupt a valid word at the output of stage 2 while it is captured by stage 3
    drive(1'b1, 1'b1, 8'h3C); step();
    drive(1'b1, 1'b0, 8'h00); step();
    step();
    held = dut.stageData[3];
    force dut.stageData[3] = held ^ 8'h01;
    step();
    release dut.stageData[3];
    drive(1'b0, 1'b0, 8'h00);
    chk("par_pre", 32'(perr), 0);
    step();
    chk("par_set", 32'(perr), 1);
    step(); step();
    chk("par_sticky", 32'(perr), 1);
    flush = 1'b1; step(); flush = 1'b0;
    chk("par_flush", 32'(perr), 0);
`else
    chk("perr_off", 32'(perr), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
